multimode_counter: RTL and testbench

- Parametrised, WIDTH-bit counter unit that succeeds the fixed 4-bit binary counter and the 8-bit ring counters.
- One register runs four selectable sequences: modulo binary up/down, bidirectional ring, Johnson, and bounce (ping-pong one-hot).
- Provides sync load, active-low enables, terminal-count pulse and load-error flag.
- Used as the general sequencer/timebase for lab datapaths and LED/scan drivers.

---
 rtl/mmc_pkg.sv | 29 ++
 rtl/multimode_counter.sv | 187 ++++++++++++++++++
 tb/tb_multimode_counter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mmc_pkg.sv
// Shared definitions for the multimode counter: sequence-select codes,
// the per-mode seed value and a one-hot test used to validate loads.
package mmc_pkg;

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_RING = 2'd1;
    localparam logic [1:0] MODE_JOHN = 2'd2;
    localparam logic [1:0] MODE_BNC  = 2'd3;

    localparam int MAX_WIDTH = 32;

    // Starting value of each sequence, returned at full width. The caller
    // truncates it to its own WIDTH. Ring and bounce start with only the
    // MSB set; binary and Johnson start from all-zero.
    function automatic logic [MAX_WIDTH-1:0] seed(input logic [1:0] mode, input int width);
        logic [MAX_WIDTH-1:0] s;
        s = '0;
        if (mode == MODE_RING || mode == MODE_BNC) begin
            s = 32'd1 << (width - 1);
        end
        return s;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] v);
        return $onehot(v);
    endfunction

endpackage

// File: rtl/multimode_counter.sv
// General-purpose WIDTH-bit sequencer. A single count register runs one of
// four sequences (modulo binary, ring, Johnson, bounce) with synchronous
// load, active-low enables, a registered terminal-count pulse and a
// registered illegal-load pulse. Every output comes straight from a flop.
module multimode_counter
    import mmc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_cnt_enable_n,
    input  logic             i_ld_enable_n,
    input  logic [WIDTH-1:0] i_load,
    input  logic [1:0]       i_mode,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_modulo,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_load_err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             load_err_q, load_err_d;
    logic [1:0]       mode_q, mode_d;
    logic             bdir_q, bdir_d;

    // Results of one enabled step in the current mode.
    logic [WIDTH-1:0] step_count;
    logic             step_tc;
    logic             step_bdir;

    // Results of a parallel load in the current mode.
    logic [WIDTH-1:0] load_count;
    logic             load_err;
    logic             load_bdir;

    logic [WIDTH-1:0] seed_cur;
    logic [WIDTH-1:0] seed_new;
    logic [WIDTH-1:0] ring_home;
    logic [WIDTH-1:0] lsb_one;

    assign seed_cur  = WIDTH'(seed(mode_q, WIDTH));
    assign seed_new  = WIDTH'(seed(i_mode, WIDTH));
    assign ring_home = WIDTH'(seed(MODE_RING, WIDTH));
    assign lsb_one   = WIDTH'(1);

    // Compute what a single counting step would produce in the active mode,
    // including whether it hits the terminal point of that sequence.
    always_comb begin
        step_count = count_q;
        step_tc    = 1'b0;
        step_bdir  = bdir_q;
        unique case (mode_q)
            MODE_BIN: begin
                // A modulo of zero makes both directions wrap every step, so
                // the count stays at zero and the terminal pulse repeats.
                if (i_dir) begin
                    if (count_q >= i_modulo) begin
                        step_count = '0;
                        step_tc    = 1'b1;
                    end else begin
                        step_count = count_q + 1'b1;
                    end
                end else begin
                    if (count_q == '0) begin
                        step_count = i_modulo;
                        step_tc    = 1'b1;
                    end else begin
                        step_count = count_q - 1'b1;
                    end
                end
            end
            MODE_RING: begin
                if (i_dir) begin
                    step_count = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
                    step_tc    = (step_count == lsb_one);
                end else begin
                    step_count = {count_q[0], count_q[WIDTH-1:1]};
                    step_tc    = (step_count == ring_home);
                end
            end
            MODE_JOHN: begin
                if (i_dir) begin
                    step_count = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
                end else begin
                    step_count = {~count_q[0], count_q[WIDTH-1:1]};
                end
                step_tc = (step_count == '0);
            end
            MODE_BNC: begin
                // The hot bit walks one place and reverses when it lands on
                // either end, so the end bits each appear once per period.
                if (bdir_q) begin
                    step_count = count_q << 1;
                end else begin
                    step_count = count_q >> 1;
                end
                if (step_count[0] || step_count[WIDTH-1]) begin
                    step_tc   = 1'b1;
                    step_bdir = ~bdir_q;
                end
            end
            default: begin
                step_count = count_q;
            end
        endcase
    end

    // Compute the outcome of a parallel load: clamp in binary, validate
    // one-hot in ring and bounce, accept anything in Johnson.
    always_comb begin
        load_count = i_load;
        load_err   = 1'b0;
        load_bdir  = bdir_q;
        unique case (mode_q)
            MODE_BIN: begin
                load_count = (i_load > i_modulo) ? i_modulo : i_load;
            end
            MODE_RING: begin
                if (!is_onehot(32'(i_load))) begin
                    load_count = seed_cur;
                    load_err   = 1'b1;
                end
            end
            MODE_JOHN: begin
                load_count = i_load;
            end
            MODE_BNC: begin
                // A loaded hot bit at bit0 can only move toward the MSB, so
                // the bounce direction is pointed upward in that one case.
                if (!is_onehot(32'(i_load))) begin
                    load_count = seed_cur;
                    load_err   = 1'b1;
                    load_bdir  = 1'b0;
                end else begin
                    load_bdir = i_load[0];
                end
            end
            default: begin
                load_count = i_load;
            end
        endcase
    end

    // Choose the next register state by priority: reset, mode change,
    // load, count, hold. Pulses default low so they last one cycle.
    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        mode_d     = mode_q;
        bdir_d     = bdir_q;
        if (!i_reset_n) begin
            count_d = ring_home;
            mode_d  = MODE_RING;
            bdir_d  = 1'b0;
        end else if (i_mode != mode_q) begin
            mode_d  = i_mode;
            count_d = seed_new;
            bdir_d  = 1'b0;
        end else if (!i_ld_enable_n) begin
            count_d    = load_count;
            load_err_d = load_err;
            bdir_d     = load_bdir;
        end else if (!i_cnt_enable_n) begin
            count_d = step_count;
            tc_d    = step_tc;
            bdir_d  = step_bdir;
        end
    end

    // Register stage holding the count, the pulses and the internal state.
    always_ff @(posedge i_clk) begin
        count_q    <= count_d;
        tc_q       <= tc_d;
        load_err_q <= load_err_d;
        mode_q     <= mode_d;
        bdir_q     <= bdir_d;
    end

    assign o_count    = count_q;
    assign o_tc       = tc_q;
    assign o_load_err = load_err_q;

endmodule

// File: tb/tb_multimode_counter.sv
// Directed bench for multimode_counter at WIDTH = 4. Each step drives the
// inputs, waits one rising edge and compares the registered outputs with
// hand-computed values.
module tb_multimode_counter;

    localparam int WIDTH = 4;

    logic             i_clk;
    logic             i_reset_n;
    logic             i_cnt_enable_n;
    logic             i_ld_enable_n;
    logic [WIDTH-1:0] i_load;
    logic [1:0]       i_mode;
    logic             i_dir;
    logic [WIDTH-1:0] i_modulo;
    logic [WIDTH-1:0] o_count;
    logic             o_tc;
    logic             o_load_err;

    int checks;
    int failures;

    multimode_counter #(.WIDTH(WIDTH)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_cnt_enable_n(i_cnt_enable_n),
        .i_ld_enable_n (i_ld_enable_n),
        .i_load        (i_load),
        .i_mode        (i_mode),
        .i_dir         (i_dir),
        .i_modulo      (i_modulo),
        .o_count       (o_count),
        .o_tc          (o_tc),
        .o_load_err    (o_load_err)
    );

    // Free-running 10 ns clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic applyStimulus(input logic rst_n, input logic cnt_n, input logic ld_n,
                                 input logic [1:0] mode, input logic dir,
                                 input logic [WIDTH-1:0] load, input logic [WIDTH-1:0] modulo);
        i_reset_n      = rst_n;
        i_cnt_enable_n = cnt_n;
        i_ld_enable_n  = ld_n;
        i_mode         = mode;
        i_dir          = dir;
        i_load         = load;
        i_modulo       = modulo;
        @(posedge i_clk);
        #1;
    endtask

    // Compare all three outputs against expected values.
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] exp_count,
                               input logic exp_tc, input logic exp_err);
        checks++;
        assert (o_count === exp_count) else begin
            failures++;
            $error("[TB] FAIL %s count: observed %b expected %b", tag, o_count, exp_count);
        end
        checks++;
        assert (o_tc === exp_tc) else begin
            failures++;
            $error("[TB] FAIL %s tc: observed %b expected %b", tag, o_tc, exp_tc);
        end
        checks++;
        assert (o_load_err === exp_err) else begin
            failures++;
            $error("[TB] FAIL %s load_err: observed %b expected %b", tag, o_load_err, exp_err);
        end
    endtask

    // Linear directed sequence covering every mode and the priority rules.
    initial begin
        logic [WIDTH-1:0] ring_exp [5];
        logic [WIDTH-1:0] john_exp [8];
        logic [WIDTH-1:0] bnc_exp  [6];
        checks   = 0;
        failures = 0;
        ring_exp = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
        john_exp = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                     4'b0111, 4'b0011, 4'b0001, 4'b0000};
        bnc_exp  = '{4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        i_reset_n = 1'b0; i_cnt_enable_n = 1'b1; i_ld_enable_n = 1'b1;
        i_mode = 2'd1; i_dir = 1'b0; i_load = '0; i_modulo = 4'd5;

        // Reset state with ring mode selected.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'd0, 4'd5);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'd0, 4'd5);
        checkOutput("reset", 4'b1000, 1'b0, 1'b0);

        // Ring rotating right; terminal pulse on return to 1000.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'd0, 4'd5);
            checkOutput($sformatf("ring_step%0d", i), ring_exp[i], (i == 3), 1'b0);
        end

        // Switch to binary: reseeds to zero.
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 4'd0, 4'd5);
        checkOutput("bin_seed", 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'd0, 4'd5);
            checkOutput($sformatf("bin_up%0d", i), 4'((i + 1) % 6), (i == 5), 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'd0, 4'd5);
        checkOutput("bin_down0", 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'd0, 4'd5);
        checkOutput("bin_down_wrap", 4'd5, 1'b1, 1'b0);

        // Johnson shifting right from zero, period 8.
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'd0, 4'd5);
        checkOutput("john_seed", 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'd0, 4'd5);
            checkOutput($sformatf("john_step%0d", i), john_exp[i], (i == 7), 1'b0);
        end

        // Bounce from the MSB seed; terminal pulse at each end.
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 4'd0, 4'd5);
        checkOutput("bnc_seed", 4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'd0, 4'd5);
            checkOutput($sformatf("bnc_step%0d", i), bnc_exp[i], (i == 2 || i == 5), 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'd0, 4'd5);
        checkOutput("bnc_turn", 4'b0100, 1'b0, 1'b0);

        // Reset mid-bounce, then confirm ring mode by counting without reseed.
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'd0, 4'd5);
        checkOutput("bnc_reset", 4'b1000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'd0, 4'd5);
        checkOutput("post_reset_ring", 4'b0100, 1'b0, 1'b0);

        // Ring loads: illegal value reseeds and flags, legal value accepted.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0110, 4'd5);
        checkOutput("ring_bad_load", 4'b1000, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0010, 4'd5);
        checkOutput("ring_good_load", 4'b0010, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000, 4'd5);
        checkOutput("ring_hold", 4'b0010, 1'b0, 1'b0);

        // Mode change wins over load; then clamped binary load.
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0011, 4'd5);
        checkOutput("mode_over_load", 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0111, 4'd5);
        checkOutput("bin_load_clamp", 4'b0101, 1'b0, 1'b0);

        // Modulo zero: count collapses to zero and tc pulses every step.
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'd0, 4'd0);
        checkOutput("mod0_a", 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'd0, 4'd0);
        checkOutput("mod0_b", 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'd0, 4'd0);
        checkOutput("mod0_down", 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'd0, 4'd0);
        checkOutput("mod0_hold", 4'b0000, 1'b0, 1'b0);

        // Bounce load of bit0 turns the walk toward the MSB.
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 4'd0, 4'd5);
        checkOutput("bnc_seed2", 4'b1000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0001, 4'd5);
        checkOutput("bnc_load_lsb", 4'b0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'd0, 4'd5);
        checkOutput("bnc_after_lsb", 4'b0010, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
